// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared types and constants for the diffEq sample sequencer
package filt_pkg;

  typedef enum logic [2:0] {IDLE, ACQ, SETTLE, CAPT, OUT} state_e;

  // Filter-type select shared with diffEq
  localparam logic FILT_LPF = 1'b0;
  localparam logic FILT_HPF = 1'b1;

  function automatic int calc_div(input int clk_hz, input int fs_hz);
    return clk_hz / fs_hz;
  endfunction

  function automatic logic [31:0] midscale(input int n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/filt_tick_gen.sv
// rtl/filt_tick_gen.sv - fs divider, one-cycle registered tick every CLK_HZ/FS_HZ clocks
module filt_tick_gen
  import filt_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int FS_HZ  = 48_000
) (
  input  logic clk_i,
  input  logic reset_ni,
  output logic tick_o
);

  localparam int DIV = calc_div(CLK_HZ, FS_HZ);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/filt_sample_seq.sv
// rtl/filt_sample_seq.sv - sample sequencer and history holder around the diffEq filter
// Define FILT_OVERRUN_CNT_EN to build the saturating dropped-tick counter.
module filt_sample_seq
  import filt_pkg::*;
#(
  parameter int N          = 10,
  parameter int CLK_HZ     = 50_000_000,
  parameter int FS_HZ      = 48_000,
  parameter int SETTLE_CYC = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   adc_data,
  input  logic           adc_valid,
  output logic           adc_ready,
  input  logic           flush,
  output logic [2*N-1:0] deq_x,
  output logic [N-1:0]   deq_y,
  output logic [16:0]    deq_fs,
  input  logic [N-1:0]   deq_out,
  output logic [N-1:0]   dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           sample_tick,
  output logic [7:0]     overrun_cnt
);

  localparam logic [31:0] MID_W = midscale(N);
  localparam logic [N-1:0] MID  = MID_W[N-1:0];
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e        state_q;
  logic [N-1:0]  x_cur_q, x_prev_q, y_prev_q, dout_q;
  logic          dout_valid_q, adc_ready_q, flush_pend_q;
  logic [SW-1:0] settle_q;
  logic          tick;

  filt_tick_gen #(
    .CLK_HZ(CLK_HZ),
    .FS_HZ (FS_HZ)
  ) u_tick (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x_cur_q      <= MID;
      x_prev_q     <= MID;
      y_prev_q     <= MID;
      dout_q       <= MID;
      dout_valid_q <= 1'b0;
      adc_ready_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      settle_q     <= '0;
    end else begin
      if (flush) flush_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // Flush lands before a same-cycle tick so ACQ starts from midscale history
          if (flush_pend_q || flush) begin
            x_cur_q      <= MID;
            x_prev_q     <= MID;
            y_prev_q     <= MID;
            flush_pend_q <= 1'b0;
          end
          if (tick) begin
            state_q     <= ACQ;
            adc_ready_q <= 1'b1;
          end
        end
        ACQ: begin
          if (adc_valid) begin
            x_prev_q    <= x_cur_q;
            x_cur_q     <= adc_data;
            adc_ready_q <= 1'b0;
            settle_q    <= SW'(SETTLE_CYC - 1);
            state_q     <= (SETTLE_CYC > 1) ? SETTLE : CAPT;
          end
        end
        SETTLE: begin
          // CAPT itself is the last settle cycle, so leave as the count reaches 0
          settle_q <= settle_q - SW'(1);
          if (settle_q <= SW'(1)) state_q <= CAPT;
        end
        CAPT: begin
          y_prev_q     <= deq_out;
          dout_q       <= deq_out;
          dout_valid_q <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FILT_OVERRUN_CNT_EN
  logic [7:0] ovr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= 8'd0;
    end else if (tick && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

  assign deq_x       = {x_cur_q, x_prev_q};
  assign deq_y       = y_prev_q;
  assign deq_fs      = 17'(FS_HZ);
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign adc_ready   = adc_ready_q;
  assign sample_tick = tick;

endmodule

// File: tb/tb_filt_sample_seq.sv
// tb/tb_filt_sample_seq.sv - directed bench for filt_sample_seq with a stubbed diffEq
module tb_filt_sample_seq;

  localparam int N = 10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   adc_data;
  logic           adc_valid;
  logic           adc_ready;
  logic           flush;
  logic [2*N-1:0] deq_x;
  logic [N-1:0]   deq_y;
  logic [16:0]    deq_fs;
  logic [N-1:0]   deq_out;
  logic [N-1:0]   dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           sample_tick;
  logic [7:0]     overrun_cnt;

  int total = 0;
  int bad   = 0;
  int gap;
  int exp_ovr;

  filt_sample_seq #(
    .N         (N),
    .CLK_HZ    (1000),
    .FS_HZ     (100),
    .SETTLE_CYC(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .adc_ready  (adc_ready),
    .flush      (flush),
    .deq_x      (deq_x),
    .deq_y      (deq_y),
    .deq_fs     (deq_fs),
    .deq_out    (deq_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sample_tick(sample_tick),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < 40);
  endtask

  initial begin
`ifdef FILT_OVERRUN_CNT_EN
    exp_ovr = 2;
`else
    exp_ovr = 0;
`endif
    reset_n    = 1'b0;
    adc_data   = '0;
    adc_valid  = 1'b0;
    flush      = 1'b0;
    deq_out    = '0;
    dout_ready = 1'b1;
    step();
    step();

    check("rst_deq_x", deq_x, {10'd512, 10'd512});
    check("rst_deq_y", deq_y, 512);
    check("rst_dout", dout, 512);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_adc_ready", adc_ready, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("deq_fs", deq_fs, 100);

    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("first_tick", sample_tick, (i == 10) ? 1 : 0);
    end

    // single sample: 700 in, stub answers 600 (glitch value before CAPT)
    adc_data = 10'd700; adc_valid = 1'b1; deq_out = 10'd600;
    step();
    check("s1_adc_ready", adc_ready, 1);
    step();
    adc_valid = 1'b0;
    check("s1_deq_x", deq_x, {10'd700, 10'd512});
    check("s1_ready_drop", adc_ready, 0);
    deq_out = 10'd999;
    step();
    deq_out = 10'd600;
    step();
    check("s1_dout", dout, 600);
    check("s1_dout_valid", dout_valid, 1);
    check("s1_deq_y", deq_y, 600);
    step();
    check("s1_valid_clr", dout_valid, 0);
    wait_tick(gap);
    check("tick_gap1", gap, 5);

    // second sample: 300 in, stub answers 450
    adc_data = 10'd300; adc_valid = 1'b1; deq_out = 10'd450;
    step();
    step();
    adc_valid = 1'b0;
    check("s2_deq_x", deq_x, {10'd300, 10'd700});
    check("s2_deq_y", deq_y, 600);
    step();
    step();
    check("s2_dout", dout, 450);
    step();
    wait_tick(gap);
    check("tick_gap2", gap, 5);

    // backpressure for 25 cycles with a flush pulse while in OUT
    adc_data = 10'd700; adc_valid = 1'b1; deq_out = 10'd600; dout_ready = 1'b0;
    step();
    step();
    adc_valid = 1'b0;
    step();
    step();
    check("bp_dout_valid", dout_valid, 1);
    for (int i = 1; i <= 25; i++) begin
      step();
      flush = (i == 11);
    end
    check("bp_dout", dout, 600);
    check("bp_dout_hold", dout_valid, 1);
    check("bp_hist_kept", deq_x, {10'd700, 10'd300});
    check("bp_overrun", overrun_cnt, exp_ovr);
    dout_ready = 1'b1;
    step();
    check("bp_tick_idle", sample_tick, 1);
    check("bp_valid_clr", dout_valid, 0);
    step();
    check("fl_deq_x", deq_x, {10'd512, 10'd512});
    check("fl_deq_y", deq_y, 512);
    check("fl_acq", adc_ready, 1);

    // reset while in SETTLE
    adc_data = 10'd100; adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    check("rs_deq_x_pre", deq_x, {10'd100, 10'd512});
    reset_n = 1'b0;
    #1;
    check("rs_deq_x", deq_x, {10'd512, 10'd512});
    check("rs_dout", dout, 512);
    check("rs_dout_valid", dout_valid, 0);
    check("rs_overrun", overrun_cnt, 0);
    step();
    reset_n = 1'b1;
    wait_tick(gap);
    check("rs_tick_gap", gap, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filt_sample_seq.md
Name: filt_sample_seq

Overview:
- Sample-rate sequencer and state holder for the combinational first-order difference-equation filter (diffEq).
- Generates the fs tick and accepts one ADC sample per tick.
- Presents x[n], x[n-1] and y[n-1] to diffEq, waits for the combinational path to settle, then captures y[n] as new feedback and as a handshaked output sample.
- Sits between the ADC front end and the DAC/output path of the guitar filter.

Parameters:
- N, 10, sample width in bits, offset-binary (midscale 2^(N-1)).
- CLK_HZ, 50_000_000, system clock frequency.
- FS_HZ, 48_000, sample rate; must be < 2^17.
- SETTLE_CYC, 2, clock cycles allowed for the diffEq combinational path (>=1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- adc_data  in  N  new sample x[n]
- adc_valid  in  1  adc_data valid
- adc_ready  out  1  sequencer accepts adc_data this cycle
- flush  in  1  one-cycle pulse: return filter history to midscale
- deq_x  out  2N  {x[n], x[n-1]} to diffEq; x[n] in the upper N bits
- deq_y  out  N  y[n-1] to diffEq
- deq_fs  out  17  constant FS_HZ to diffEq
- deq_out  in  N  y[n] from diffEq
- dout  out  N  filtered sample
- dout_valid  out  1  dout valid
- dout_ready  in  1  downstream accepts dout
- sample_tick  out  1  one-cycle fs strobe
- overrun_cnt  out  8  dropped-tick counter (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0):
  - x_cur, x_prev, y_prev, dout = 2^(N-1).
  - dout_valid=0, adc_ready=0, sample_tick=0, overrun_cnt=0.
  - Divider=0, state=IDLE.
- Tick divider: counts 0..DIV-1, with DIV = CLK_HZ/FS_HZ (integer, truncated). sample_tick=1 on the cycle the count wraps to 0. The first tick comes DIV cycles after reset release.
- FSM states:
  - IDLE: on sample_tick, go to ACQ.
  - ACQ: adc_ready=1. When adc_valid=1, x_prev<=x_cur and x_cur<=adc_data; go to SETTLE. The settle counter loads SETTLE_CYC-1.
  - SETTLE: decrement the counter each cycle; at 0 go to CAPT.
  - CAPT (1 cycle): y_prev<=deq_out, dout<=deq_out, dout_valid<=1; go to OUT.
  - OUT: hold dout/dout_valid until dout_ready=1, then clear dout_valid and go to IDLE.
- adc_ready is asserted only in ACQ. A sample offered outside ACQ is not consumed.
- Latency: from adc handshake cycle T, dout_valid rises at T+SETTLE_CYC+1 (minimum 3 cycles at the default).
- Outputs are combinational from registers: deq_x={x_cur,x_prev}, deq_y=y_prev.
- Overrun: a sample_tick while state!=IDLE is dropped, and overrun_cnt increments, saturating at 255. A tick landing on the cycle OUT→IDLE is also dropped.
- Flush:
  - Sets a pending flag. The flag is applied on the next cycle in IDLE: x_cur, x_prev, y_prev <= 2^(N-1); flag clears.
  - Flush during SETTLE/CAPT/OUT does not corrupt the in-flight sample.
  - Flush and a tick in the same IDLE cycle: flush is applied first, the tick is still honoured, and ACQ starts from midscale history.
- deq_out is sampled only in CAPT; glitches elsewhere are ignored.
- Reset mid-operation: immediate return to reset values; a pending dout is discarded.

Optional Feature:
- Macro: FILT_OVERRUN_CNT_EN.
- Defined: overrun_cnt behaves as above.
- Undefined: the counter logic is omitted and overrun_cnt is tied to 0. Tick dropping is unchanged.

Decomposition:
- Package filt_pkg:
  - state enum typedef {IDLE, ACQ, SETTLE, CAPT, OUT}.
  - localparam function for the midscale value.
  - DIV computation.
  - LPF/HPF filt_type constants (0/1), shared with diffEq.
- One natural sub-module: filt_tick_gen (divider producing sample_tick, parameterised by CLK_HZ/FS_HZ).

Test Plan (N=10, CLK_HZ=1000, FS_HZ=100 → DIV=10, SETTLE_CYC=2; diffEq replaced by a stub driving deq_out):
- Reset: after reset_n release → deq_x={512,512}, deq_y=512, dout_valid=0. First sample_tick at cycle 10, then every 10 cycles.
- Single sample: adc_data=700 handshaked at cycle T, stub deq_out=600 → deq_x={700,512} from T+1; dout=600, dout_valid=1 at T+3; deq_y=600 afterwards.
- Two samples: 700 then 300, stub 600 then 450 → second deq_x={300,700}, deq_y=600; dout=450.
- Backpressure: dout_ready held low 25 cycles after dout_valid → 2 ticks dropped, overrun_cnt=2, dout stable at 600. With the macro undefined, overrun_cnt=0.
- Flush: pulse flush while in OUT → in-flight dout unchanged. The next IDLE cycle restores deq_x={512,512} and deq_y=512 before the next ACQ.
- Reset mid-SETTLE: reset_n low for 1 cycle → dout_valid=0, history=512, and the next tick arrives 10 cycles after release.
